// File: rtl/series_eval_ctrl_pkg.sv
// series_ctrl_pkg: state encoding and default sizing for the series-evaluation sequencer
package series_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    INIT   = 3'd2,
    MULT   = 3'd3,
    LOAD_Y = 3'd4,
    SUM    = 3'd5,
    NEXT   = 3'd6,
    DONE   = 3'd7
  } state_e;
  localparam int DEF_N_TERMS = 6;
  localparam int DEF_MULT_CYCLES = 1;
endpackage

// File: rtl/series_eval_ctrl_if.sv
// series_eval_ctrl_if: host handshake and datapath strobe bundle of the series sequencer
interface series_eval_ctrl_if #(parameter int IDX_W = 3);
  logic start, ready, ack, done, term_zero, read, clr_acc, select_y, load_y, mult, sum;
  logic [IDX_W-1:0] term_idx;
  modport master(output start, ack, term_zero, input ready, done, read, clr_acc, select_y, load_y, mult, sum, term_idx);
  modport slave(input start, ack, term_zero, output ready, done, read, clr_acc, select_y, load_y, mult, sum, term_idx);
endinterface

// File: rtl/series_eval_ctrl_mult_wait_counter.sv
// mult_wait_counter: down-counter timing the MULT hold; expire marks the last multiply cycle
module mult_wait_counter #(parameter int MULT_CYCLES = 1) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = MULT_CYCLES > 1 ? $clog2(MULT_CYCLES) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= CW'(MULT_CYCLES - 1);
    else if (en && cnt != '0) cnt <= cnt - CW'(1);
  assign expire = cnt == '0;
endmodule

// File: rtl/series_eval_ctrl.sv
// series_eval_ctrl: Moore sequencer for the series-evaluation datapath.
// SERIES_CTRL_EARLY_EXIT_EN: finish in SUM as soon as the datapath reports a zero term.
module series_eval_ctrl
  import series_ctrl_pkg::*;
#(
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int IDX_W = 3
) (
  input logic clk,
  input logic reset,
  series_eval_ctrl_if.slave bus
);
  state_e state, state_nx;
  logic [IDX_W-1:0] term_idx;
  logic expire, last;
  mult_wait_counter #(.MULT_CYCLES(MULT_CYCLES)) u_wait (
    .clk(clk),
    .reset(reset),
    .load(state != MULT),
    .en(state == MULT),
    .expire(expire)
  );
`ifdef SERIES_CTRL_EARLY_EXIT_EN
  assign last = term_idx == IDX_W'(N_TERMS - 1) || bus.term_zero;
`else
  logic unused_term_zero;
  assign unused_term_zero = bus.term_zero;
  assign last = term_idx == IDX_W'(N_TERMS - 1);
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = bus.start ? READ : IDLE;
      READ:    state_nx = INIT;
      INIT:    state_nx = MULT;
      MULT:    state_nx = expire ? LOAD_Y : MULT;
      LOAD_Y:  state_nx = SUM;
      SUM:     state_nx = last ? DONE : NEXT;
      NEXT:    state_nx = MULT;
      DONE:    state_nx = bus.ack ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) term_idx <= '0;
    else if (state == READ) term_idx <= '0;
    else if (state == NEXT) term_idx <= term_idx + IDX_W'(1);
  assign bus.ready = state == IDLE;
  assign bus.done = state == DONE;
  assign bus.read = state == READ;
  assign bus.clr_acc = state == READ;
  assign bus.load_y = state == INIT || state == LOAD_Y;
  assign bus.select_y = state == LOAD_Y;
  assign bus.mult = state == MULT;
  assign bus.sum = state == SUM;
  assign bus.term_idx = term_idx;
endmodule

// File: tb/tb_series_eval_ctrl.sv
// tb_series_eval_ctrl: scoreboard bench for the series sequencer (default and N=2/MULT=3 instances)
module tb_series_eval_ctrl;
  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int failures = 0;
  series_eval_ctrl_if #(.IDX_W(3)) b0();
  series_eval_ctrl_if #(.IDX_W(3)) b1();
  series_eval_ctrl #(.N_TERMS(6), .MULT_CYCLES(1), .IDX_W(3)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  series_eval_ctrl #(.N_TERMS(2), .MULT_CYCLES(3), .IDX_W(3)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  always #5 clk = ~clk;

  function automatic logic [7:0] flags0();
    return {b0.ready, b0.done, b0.read, b0.clr_acc, b0.select_y, b0.load_y, b0.mult, b0.sum};
  endfunction

  task automatic test_reset();
    b0.start = 0; b0.ack = 0; b0.term_zero = 0;
    b1.start = 0; b1.ack = 0; b1.term_zero = 0;
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (flags0() !== 8'b1000_0000 || b0.term_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_u0: flags=%b idx=%0d expected flags=10000000 idx=0", flags0(), b0.term_idx);
    end
    checks++;
    if ({b1.ready, b1.done, b1.mult, b1.sum} !== 4'b1000 || b1.term_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_u1: rdy/done/mult/sum=%b idx=%0d expected 1000 idx=0",
               {b1.ready, b1.done, b1.mult, b1.sum}, b1.term_idx);
    end
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_series();
    logic [2:0] q[$];
    logic [2:0] exp_idx;
    logic [5:0] s;
    int edges;
    for (int i = 0; i < 6; i++) q.push_back(3'(i));
    b0.start = 1;
    @(negedge clk);
    b0.start = 0;
    edges = 0;
    while (!b0.done && edges < 100) begin
      s = {b0.read, b0.clr_acc, b0.select_y, b0.load_y, b0.mult, b0.sum};
      checks++;
      if (!(s inside {6'b000000, 6'b110000, 6'b000100, 6'b001100, 6'b000010, 6'b000001}) || b0.ready !== 1'b0) begin
        failures++;
        $display("FAIL series_strobes: edge=%0d strobes=%b ready=%b expected one legal group, ready=0", edges, s, b0.ready);
      end
      if (edges == 0) begin
        checks++;
        if (s !== 6'b110000) begin
          failures++;
          $display("FAIL series_read: strobes=%b expected 110000", s);
        end
      end
      if (edges == 1) begin
        checks++;
        if (s !== 6'b000100) begin
          failures++;
          $display("FAIL series_init: strobes=%b expected 000100", s);
        end
      end
      if (b0.sum) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL series_extra_sum: idx=%0d expected no further sum", b0.term_idx);
        end else begin
          exp_idx = q.pop_front();
          if (b0.term_idx !== exp_idx) begin
            failures++;
            $display("FAIL series_sum_idx: idx=%0d expected %0d", b0.term_idx, exp_idx);
          end
        end
      end
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges != 25 || q.size() != 0) begin
      failures++;
      $display("FAIL series_latency: edges=%0d pending_sums=%0d expected 25 and 0", edges, q.size());
    end
    b0.ack = 1;
    @(negedge clk);
    b0.ack = 0;
    checks++;
    if (flags0() !== 8'b1000_0000 || b0.term_idx !== 3'd5) begin
      failures++;
      $display("FAIL series_ack: flags=%b idx=%0d expected 10000000 idx=5", flags0(), b0.term_idx);
    end
  endtask

  task automatic test_multicycle();
    logic [2:0] q[$];
    logic [2:0] exp_idx;
    int edges, run;
    q.push_back(3'd0);
    q.push_back(3'd1);
    run = 0;
    b1.start = 1;
    @(negedge clk);
    b1.start = 0;
    edges = 0;
    while (!b1.done && edges < 100) begin
      if (b1.mult) run++;
      else if (run != 0) begin
        checks++;
        if (run != 3) begin
          failures++;
          $display("FAIL mult_hold: cycles=%0d expected 3", run);
        end
        run = 0;
      end
      if (b1.sum) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL mult_extra_sum: idx=%0d expected no further sum", b1.term_idx);
        end else begin
          exp_idx = q.pop_front();
          if (b1.term_idx !== exp_idx) begin
            failures++;
            $display("FAIL mult_sum_idx: idx=%0d expected %0d", b1.term_idx, exp_idx);
          end
        end
      end
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges != 13 || q.size() != 0) begin
      failures++;
      $display("FAIL mult_latency: edges=%0d pending_sums=%0d expected 13 and 0", edges, q.size());
    end
    b1.ack = 1;
    @(negedge clk);
    b1.ack = 0;
    checks++;
    if (b1.ready !== 1'b1 || b1.done !== 1'b0) begin
      failures++;
      $display("FAIL mult_ack: ready=%b done=%b expected 1 0", b1.ready, b1.done);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    b0.start = 1;
    edges = 0;
    @(negedge clk);
    while (!b0.done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    checks++;
    if (!b0.done) begin
      failures++;
      $display("FAIL b2b_done_timeout: done=%b expected 1 within 100 cycles", b0.done);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (b0.done !== 1'b1 || b0.ready !== 1'b0 || b0.read !== 1'b0) begin
        failures++;
        $display("FAIL b2b_hold: cycle=%0d done=%b ready=%b read=%b expected 1 0 0", i, b0.done, b0.ready, b0.read);
      end
    end
    b0.ack = 1;
    @(negedge clk);
    b0.ack = 0;
    checks++;
    if (b0.ready !== 1'b1 || b0.done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_release: ready=%b done=%b expected 1 0", b0.ready, b0.done);
    end
    @(negedge clk);
    b0.start = 0;
    checks++;
    if (b0.read !== 1'b1 || b0.ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: read=%b ready=%b expected 1 0", b0.read, b0.ready);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    edges = 0;
    while (!(b0.mult && b0.term_idx == 3'd3) && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    checks++;
    if (!(b0.mult && b0.term_idx == 3'd3)) begin
      failures++;
      $display("FAIL midreset_reach: mult=%b idx=%0d expected mult=1 idx=3", b0.mult, b0.term_idx);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (flags0() !== 8'b1000_0000 || b0.term_idx !== 3'd0) begin
      failures++;
      $display("FAIL midreset_async: flags=%b idx=%0d expected 10000000 idx=0", flags0(), b0.term_idx);
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if (flags0() !== 8'b1000_0000) begin
      failures++;
      $display("FAIL midreset_idle: flags=%b expected 10000000", flags0());
    end
  endtask

  task automatic test_early_exit();
    logic [2:0] q[$];
    logic [2:0] exp_idx;
    int edges, exp_edges;
`ifdef SERIES_CTRL_EARLY_EXIT_EN
    for (int i = 0; i < 2; i++) q.push_back(3'(i));
    exp_edges = 9;
`else
    for (int i = 0; i < 6; i++) q.push_back(3'(i));
    exp_edges = 25;
`endif
    b0.start = 1;
    @(negedge clk);
    b0.start = 0;
    edges = 0;
    while (!b0.done && edges < 100) begin
      b0.term_zero = b0.sum && b0.term_idx == 3'd1;
      if (b0.sum) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL early_extra_sum: idx=%0d expected no further sum", b0.term_idx);
        end else begin
          exp_idx = q.pop_front();
          if (b0.term_idx !== exp_idx) begin
            failures++;
            $display("FAIL early_sum_idx: idx=%0d expected %0d", b0.term_idx, exp_idx);
          end
        end
      end
      @(negedge clk);
      edges++;
    end
    b0.term_zero = 0;
    checks++;
    if (edges != exp_edges || q.size() != 0) begin
      failures++;
      $display("FAIL early_latency: edges=%0d pending_sums=%0d expected %0d and 0", edges, q.size(), exp_edges);
    end
    b0.ack = 1;
    @(negedge clk);
    b0.ack = 0;
  endtask

  initial begin
    test_reset();
    test_series();
    test_multicycle();
    test_back_to_back();
    test_reset_mid();
    test_early_exit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded limit");
    $fatal(1);
  end
endmodule
